mem_arbiter: RTL and testbench

- Arbitrates the single-port program/data memory between two requesters: port 0 (CPU bus) and port 1 (debug/program loader).
- Grants one access at a time, round-robin fair, and sequences each grant through a fixed issue/response pipeline to a synchronous-read memory.
- Sits between the CPU address/data path, the loader, and the memory macro.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sequencing one access at a time to a sync-read memory.
// Define ARB_LOCK_EN to add lock0/lock1 inputs that let the last winner keep the memory for up to MAX_LOCK re-grants.
module mem_arbiter #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata1,
`ifdef ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DWIDTH-1:0] rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DWIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    state_t state;
    logic   last_winner;
    logic   take;
    logic   win;
    logic   locked;
    logic   wsel;
    logic [AWIDTH-1:0] asel;
    logic [DWIDTH-1:0] dsel;

    if (MAX_LOCK < 1) begin : g_bad_max_lock
        $error("mem_arbiter: MAX_LOCK must be at least 1");
    end

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    logic [CW-1:0] lock_cnt;
    logic          own_req, own_lock, other_req;

    // Locking only applies at the RESP edge, i.e. a back-to-back re-grant.
    always_comb begin
        own_req   = last_winner ? req1  : req0;
        own_lock  = last_winner ? lock1 : lock0;
        other_req = last_winner ? req0  : req1;
        locked    = (state == RESP) && own_lock && own_req &&
                    !((lock_cnt == CW'(MAX_LOCK)) && other_req);
    end
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        take = req0 | req1;
        if (locked)
            win = last_winner;
        else if (req0 && req1)
            win = ~last_winner;
        else
            win = req1;
        wsel = win ? we1    : we0;
        asel = win ? addr1  : addr0;
        dsel = win ? wdata1 : wdata0;
    end

    // Memory output is registered by the macro, so read data is simply forwarded.
    assign rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            last_winner <= 1'b1;
`ifdef ARB_LOCK_EN
            lock_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE, RESP: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    if (take) begin
                        state       <= SERVE;
                        last_winner <= win;
                        gnt0        <= ~win;
                        gnt1        <= win;
                        mem_re      <= ~wsel;
                        mem_we      <= wsel;
                        mem_addr    <= asel;
                        mem_wdata   <= dsel;
`ifdef ARB_LOCK_EN
                        if (!locked)
                            lock_cnt <= '0;
                        else if (lock_cnt != CW'(MAX_LOCK))
                            lock_cnt <= lock_cnt + 1'b1;
`endif
                    end else begin
                        state <= IDLE;
`ifdef ARB_LOCK_EN
                        lock_cnt <= '0;
`endif
                    end
                end
                SERVE: begin
                    state  <= RESP;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    done0  <= gnt0;
                    done1  <= gnt1;
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions queued at drive time, checked on done pulses.
module tb_mem_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
`ifdef ARB_LOCK_EN
    logic lock0 = 1'b0, lock1 = 1'b0;
`endif
    logic gnt0, gnt1, done0, done1, mem_re, mem_we;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
`ifdef ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous-read memory macro model; a few locations preloaded while in reset.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (rst) begin
            mem[5'h0A] <= 8'h3C;
            mem[5'h01] <= 8'h11;
            mem[5'h02] <= 8'h22;
        end
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic          port;
        logic          we;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] exp_mem [32];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic p, input logic w, input logic [DW-1:0] d);
        sb.push_back(exp_t'{port: p, we: w, data: d});
    endtask

    always @(negedge clk) begin
        if (done0 | done1) begin
            chk("excl", {30'b0, gnt0 & gnt1, done0 & done1}, 32'h0);
            if (sb.size() == 0) begin
                chk("sb_empty", 32'h1, 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_port", {31'b0, done1}, {31'b0, mon_e.port});
                if (!mon_e.we) chk("rdata", {24'b0, rdata}, {24'b0, mon_e.data});
            end
        end
    end

    task automatic drive(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic wait_gnt(input logic p);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) begin got = 1'b1; break; end
        end
        if (!got) chk("gnt_timeout", 32'h0, 32'h1);
    endtask

    task automatic access(input logic p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        push(p, w, w ? 8'h00 : exp_mem[a]);
        if (w) exp_mem[a] = d;
        drive(p, w, a, d);
        wait_gnt(p);
        @(posedge clk); #1;
        if (!p) req0 = 1'b0; else req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    logic pat [6];

    initial begin
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
        exp_mem[5'h0A] = 8'h3C;
        exp_mem[5'h01] = 8'h11;
        exp_mem[5'h02] = 8'h22;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {13'b0, gnt0, gnt1, done0, done1, mem_re, mem_we, mem_addr, mem_wdata}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // port 0 read of 0x0A
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'h0A, 8'h00);
        push(1'b0, 1'b0, 8'h3C);
        @(posedge clk); @(negedge clk);
        chk("t1_serve", {23'b0, gnt0, gnt1, mem_re, mem_we, mem_addr}, {23'b0, 4'b1010, 5'h0A});
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        chk("t1_resp", {28'b0, done0, done1, mem_re, mem_we}, {28'b0, 4'b1000});
        @(negedge clk);
        chk("t1_idle", {26'b0, gnt0, gnt1, done0, done1, mem_re, mem_we}, 32'h0);
        @(posedge clk); #1;

        // port 1 write 0x1F <= 0xA5
        drive(1'b1, 1'b1, 5'h1F, 8'hA5);
        push(1'b1, 1'b1, 8'h00);
        exp_mem[5'h1F] = 8'hA5;
        @(posedge clk); @(negedge clk);
        chk("t2_serve", {15'b0, gnt1, gnt0, mem_we, mem_re, mem_addr, mem_wdata}, {15'b0, 4'b1010, 5'h1F, 8'hA5});
        @(posedge clk); #1 req1 = 1'b0;
        @(negedge clk);
        chk("t2_resp", {28'b0, done1, done0, mem_we, mem_re}, {28'b0, 4'b1000});
        @(posedge clk); #1;
        access(1'b0, 1'b0, 5'h1F, 8'h00);
        access(1'b1, 1'b0, 5'h0A, 8'h00);

        // both held from reset: round-robin (or lock burst)
        @(posedge clk); #1;
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h01;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h02;
`ifdef ARB_LOCK_EN
        lock0 = 1'b1;
        pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 6; i++) push(pat[i], 1'b0, pat[i] ? 8'h22 : 8'h11);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            int  wc;
            logic got;
            got = 1'b0;
            wc  = 0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (gnt0 | gnt1) begin got = 1'b1; wc = c; break; end
            end
            if (!got) chk("t3_timeout", 32'h0, 32'h1);
            else begin
                chk("t3_port", {31'b0, gnt1}, {31'b0, pat[i]});
                if (i > 0) chk("t3_gap", wc, 32'd2);
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
`ifdef ARB_LOCK_EN
        lock0 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // reset during a write's SERVE cycle, then a pending read
        drive(1'b0, 1'b1, 5'h03, 8'h77);
        @(posedge clk); @(negedge clk);
        chk("t4_serve", {30'b0, gnt0, mem_we}, {30'b0, 2'b11});
        rst = 1'b1;
        we0 = 1'b0; addr0 = 5'h0A;
        push(1'b0, 1'b0, 8'h3C);
        @(negedge clk);
        chk("t4_rst", {13'b0, gnt0, gnt1, done0, done1, mem_re, mem_we, mem_addr, mem_wdata}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        wait_gnt(1'b0);
        @(posedge clk); #1 req0 = 1'b0;
        repeat (3) @(posedge clk);

        chk("sb_left", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
